// File: rtl/key_conditioner.sv
// key_conditioner: front end for the push-button lock.
// Synchronises the raw enter/change buttons and the four password switches,
// debounces each button with its own press/release FSM producing a one-cycle
// qualified pulse plus a held level, and debounces the switch word into a
// password that never changes on a cycle where a button pulse is high.

module key_button_fsm #(
   parameter int DB_COUNT = 250000,
   parameter int CNT_W    = 18
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pressed_i,     // synchronised, active-high "button is down"
   output logic pulse_o,       // registered one-cycle qualified-press pulse
   output logic pulse_next_o,  // value pulse_o takes at the next edge
   output logic held_o         // high in HELD and REL_WAIT
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } state_t;

   // Terminal count: the counter never goes past this value.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             held_q, held_d;

   // State, counter and registered outputs; reset parks the FSM in REL_WAIT
   // so a button held through reset must be released before it can pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= REL_WAIT;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         held_q  <= held_d;
      end
   end

   // Next-state, counter and output decode for the press/release debounce.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pressed_i) begin
               state_d = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (!pressed_i) begin
               // Any released sample during qualification is a bounce.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            cnt_d = '0;
            if (!pressed_i) begin
               state_d = REL_WAIT;
            end
         end
         REL_WAIT: begin
            if (pressed_i) begin
               // Release bounce: back to HELD without a second pulse.
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == HELD) || (state_d == REL_WAIT);
   end

   assign pulse_o      = pulse_q;
   assign pulse_next_o = pulse_d;
   assign held_o       = held_q;

endmodule

module key_conditioner #(
   parameter int DB_COUNT = 250000,
   parameter int CNT_W    = 18
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       enter_n,
   input  logic       change_n,
   input  logic [3:0] sw,
   output logic       enterpulse,
   output logic       changepulse,
   output logic       enterheld,
   output logic       changeheld,
   output logic [3:0] password
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   // Two-flop synchronisers; buttons idle high (released), switches idle low.
   logic       ent_s1_q, ent_s2_q;
   logic       chg_s1_q, chg_s2_q;
   logic [3:0] sw_s1_q, sw_s2_q;

   // Password debounce state.
   logic [3:0]       pw_q, pw_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] run;

   logic ent_pulse_next, chg_pulse_next;

   // Synchronise every raw input before any other use.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         ent_s1_q <= 1'b1;
         ent_s2_q <= 1'b1;
         chg_s1_q <= 1'b1;
         chg_s2_q <= 1'b1;
         sw_s1_q  <= 4'b0000;
         sw_s2_q  <= 4'b0000;
      end else begin
         ent_s1_q <= enter_n;
         ent_s2_q <= ent_s1_q;
         chg_s1_q <= change_n;
         chg_s2_q <= chg_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   key_button_fsm #(
      .DB_COUNT (DB_COUNT),
      .CNT_W    (CNT_W)
   ) u_enter (
      .clk_i        (Clock),
      .rst_ni       (Resetn),
      .pressed_i    (~ent_s2_q),
      .pulse_o      (enterpulse),
      .pulse_next_o (ent_pulse_next),
      .held_o       (enterheld)
   );

   key_button_fsm #(
      .DB_COUNT (DB_COUNT),
      .CNT_W    (CNT_W)
   ) u_change (
      .clk_i        (Clock),
      .rst_ni       (Resetn),
      .pressed_i    (~chg_s2_q),
      .pulse_o      (changepulse),
      .pulse_next_o (chg_pulse_next),
      .held_o       (changeheld)
   );

   // Password debounce registers.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pw_q   <= 4'b0000;
         cand_q <= 4'b0000;
         pcnt_q <= '0;
      end else begin
         pw_q   <= pw_d;
         cand_q <= cand_d;
         pcnt_q <= pcnt_d;
      end
   end

   // Count consecutive identical synced samples that differ from the current
   // password; run is the zero-based index of this sample within its run,
   // saturating at the terminal count. The load is held off while either
   // button pulse is about to be high, so the password is stable on pulses.
   always_comb begin
      pw_d   = pw_q;
      cand_d = sw_s2_q;
      pcnt_d = '0;
      run    = '0;
      if (sw_s2_q == cand_q) begin
         run = (pcnt_q == CNT_LAST) ? CNT_LAST : pcnt_q + 1'b1;
      end
      if (sw_s2_q != pw_q) begin
         pcnt_d = run;
         if ((run == CNT_LAST) && !(ent_pulse_next || chg_pulse_next)) begin
            pw_d   = sw_s2_q;
            pcnt_d = '0;
         end
      end
   end

   assign password = pw_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with DB_COUNT=4.
// Expected pulse cycles and password updates are queued when stimulus is
// driven and compared by a negedge monitor when the DUT produces them.

module tb_key_conditioner;

   localparam int DB  = 4;
   localparam int LAT = DB + 3;   // raw edge to pulse edge
   localparam int PWL = DB + 2;   // raw edge to password load edge

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enter_n, change_n;
   logic [3:0] sw;
   logic       enterpulse, changepulse, enterheld, changeheld;
   logic [3:0] password;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int p;

   int         ent_q[$];
   int         chg_q[$];
   logic [3:0] pwv_q[$];
   int         pwc_q[$];
   logic [3:0] pw_prev = 4'b0000;

   key_conditioner #(
      .DB_COUNT (DB),
      .CNT_W    (18)
   ) dut (
      .Clock       (clk),
      .Resetn      (rst_n),
      .enter_n     (enter_n),
      .change_n    (change_n),
      .sw          (sw),
      .enterpulse  (enterpulse),
      .changepulse (changepulse),
      .enterheld   (enterheld),
      .changeheld  (changeheld),
      .password    (password)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Scoreboard monitor: every observed pulse or password change pops one entry.
   always @(negedge clk) begin
      if (enterpulse) begin
         if (ent_q.size() == 0) chk("ent_unexpected_pulse", cyc, -1);
         else                   chk("ent_pulse_cycle", cyc, ent_q.pop_front());
      end
      if (changepulse) begin
         if (chg_q.size() == 0) chk("chg_unexpected_pulse", cyc, -1);
         else                   chk("chg_pulse_cycle", cyc, chg_q.pop_front());
      end
      if (rst_n && (password !== pw_prev)) begin
         if (pwv_q.size() == 0) begin
            chk("pw_unexpected_change", int'(password), int'(pw_prev));
         end else begin
            chk("pw_value", int'(password), int'(pwv_q.pop_front()));
            chk("pw_cycle", cyc, pwc_q.pop_front());
         end
         pw_prev = password;
      end
   end

   initial begin
      rst_n    = 1'b0;
      enter_n  = 1'b1;
      change_n = 1'b1;
      sw       = 4'b0000;
      #1;
      chk("rst_enterpulse", enterpulse, 0);
      chk("rst_changepulse", changepulse, 0);
      chk("rst_enterheld", enterheld, 0);
      chk("rst_changeheld", changeheld, 0);
      chk("rst_password", password, 0);
      step(3);
      rst_n = 1'b1;
      step(10);

      // Single press held for a long time: one pulse, no repeat.
      p = cyc;
      enter_n = 1'b0;
      ent_q.push_back(p + LAT);
      step(LAT - 1);
      chk("ent_held_before_pulse", enterheld, 0);
      step(1);
      chk("ent_pulse_at_latency", enterpulse, 1);
      chk("ent_held_at_pulse", enterheld, 1);
      step(100);
      chk("ent_held_long", enterheld, 1);
      enter_n = 1'b1;
      step(12);
      chk("ent_held_after_release", enterheld, 0);

      // Short glitches never qualify.
      for (int g = 0; g < 5; g++) begin
         enter_n = 1'b0;
         step(3);
         enter_n = 1'b1;
         step(4);
         chk("glitch_held", enterheld, 0);
      end
      step(8);

      // Both buttons on the same edge.
      p = cyc;
      enter_n  = 1'b0;
      change_n = 1'b0;
      ent_q.push_back(p + LAT);
      chg_q.push_back(p + LAT);
      step(LAT);
      chk("both_ent_pulse", enterpulse, 1);
      chk("both_chg_pulse", changepulse, 1);
      step(1);
      chk("both_ent_single", enterpulse, 0);
      chk("both_chg_single", changepulse, 0);
      enter_n  = 1'b1;
      change_n = 1'b1;
      step(12);

      // Change held through reset: no pulse until released and pressed again.
      change_n = 1'b0;
      step(1);
      rst_n = 1'b0;
      #1;
      chk("chg_rst_held_zero", changeheld, 0);
      step(2);
      rst_n = 1'b1;
      step(20);
      chk("chg_held_through_reset", changeheld, 1);
      change_n = 1'b1;
      step(10);
      p = cyc;
      change_n = 1'b0;
      chg_q.push_back(p + LAT);
      step(10);
      chk("chg_held_after_press", changeheld, 1);
      change_n = 1'b1;
      step(12);

      // Reset during PRESS_WAIT aborts qualification.
      enter_n = 1'b0;
      step(4);
      rst_n = 1'b0;
      #1;
      chk("pw_rst_enterpulse", enterpulse, 0);
      chk("pw_rst_enterheld", enterheld, 0);
      chk("pw_rst_changepulse", changepulse, 0);
      chk("pw_rst_password", password, 0);
      step(2);
      rst_n = 1'b1;
      step(15);
      chk("pw_rst_held_after", enterheld, 1);
      enter_n = 1'b1;
      step(12);

      // Reset during the pulse cycle clears outputs at once.
      p = cyc;
      enter_n = 1'b0;
      ent_q.push_back(p + LAT);
      step(LAT);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("pulse_rst_enterpulse", enterpulse, 0);
      chk("pulse_rst_enterheld", enterheld, 0);
      step(2);
      rst_n = 1'b1;
      step(15);
      enter_n = 1'b1;
      step(12);

      // Switch bounce: 0110 with two short excursions to 0111.
      sw = 4'b0110; step(2);
      sw = 4'b0111; step(2);
      sw = 4'b0110; step(2);
      sw = 4'b0111; step(2);
      p = cyc;
      sw = 4'b0110;
      pwv_q.push_back(4'b0110);
      pwc_q.push_back(p + PWL);
      step(PWL - 1);
      chk("pw_not_yet_loaded", password, 0);
      step(1);
      chk("pw_loaded", password, 6);
      step(5);

      // Password load colliding with an enter pulse defers by one cycle.
      p = cyc;
      enter_n = 1'b0;
      ent_q.push_back(p + LAT);
      step(1);
      sw = 4'b1001;
      pwv_q.push_back(4'b1001);
      pwc_q.push_back(p + LAT + 1);
      step(LAT - 1);
      chk("pw_stable_on_pulse", password, 6);
      chk("pulse_with_pw_conflict", enterpulse, 1);
      step(1);
      chk("pw_deferred_load", password, 9);
      enter_n = 1'b1;
      step(12);

      step(5);
      chk("ent_queue_drained", ent_q.size(), 0);
      chk("chg_queue_drained", chg_q.size(), 0);
      chk("pw_queue_drained", pwv_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
